// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between instruction fetch and data access.
// Data wins arbitration, bounded by a fetch-starvation counter; LL/SC is resolved here.
//
// state   | meaning
// IDLE    | no RAM strobes; arbitrating pending requests
// I_XFER  | fetch owns the RAM until ramstate reports ACCESS/ERROR
// D_XFER  | data port owns the RAM (load, store, LL, or a winning SC)
// SC_FAIL | SC rejected locally: one-cycle dhit with dload = 0
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dren,
    input  logic              dwen,
    input  logic              dll,
    input  logic              dsc,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    output logic              ramren,
    output logic              ramwen,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_XFER  = 2'd1,
        D_XFER  = 2'd2,
        SC_FAIL = 2'd3
    } state_e;

    localparam logic [1:0] RS_ACCESS   = 2'd2;
    localparam logic [1:0] RS_ERROR    = 2'd3;
    localparam logic [3:0] DSTREAK_MAX = 4'(MAX_DSTREAK);

    state_e            state_q, state_d;
    logic [3:0]        dstreak_q, dstreak_d;
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;

    logic d_req;
    logic d_read;
    logic link_match;
    logic sc_doomed;
    logic fetch_forced;
    logic owner_active;
    logic xfer_done;
    logic xfer_err;

    assign d_req        = dren | dwen;
    // both strobes high is treated as a write
    assign d_read       = dren & ~dwen;
    assign link_match   = link_valid_q && (link_addr_q == daddr);
    assign sc_doomed    = dwen && dsc && !link_match;
    assign fetch_forced = iren && (dstreak_q == DSTREAK_MAX);

    always_comb begin
        owner_active = 1'b0;
        if (state_q == I_XFER) begin
            owner_active = iren;
        end else if (state_q == D_XFER) begin
            owner_active = d_req;
        end
    end

    assign xfer_done = owner_active && (ramstate == RS_ACCESS);
    assign xfer_err  = owner_active && (ramstate == RS_ERROR);

    // state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            dstreak_q    <= 4'd0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            dstreak_q    <= dstreak_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sc_doomed) begin
                    state_d = SC_FAIL;
                end else if (d_req && !fetch_forced) begin
                    state_d = D_XFER;
                end else if (iren) begin
                    state_d = I_XFER;
                end
            end
            I_XFER, D_XFER: begin
                // withdrawal, completion and RAM error all release the RAM
                if (!owner_active || xfer_done || xfer_err) begin
                    state_d = IDLE;
                end
            end
            SC_FAIL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dstreak_d = dstreak_q;
        if (state_q == IDLE) begin
            if (!iren) begin
                dstreak_d = 4'd0;
            end else if (state_d == D_XFER) begin
                if (dstreak_q < DSTREAK_MAX) begin
                    dstreak_d = dstreak_q + 4'd1;
                end
            end else if (state_d == I_XFER) begin
                dstreak_d = 4'd0;
            end
        end
    end

    // link register changes only on a completed data access
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (state_q == D_XFER && xfer_done) begin
            if (d_read && dll) begin
                link_valid_d = 1'b1;
                link_addr_d  = daddr;
            end else if (dwen && dsc) begin
                link_valid_d = 1'b0;
            end else if (dwen && (daddr == link_addr_q)) begin
                link_valid_d = 1'b0;
            end
        end
    end

    // output logic
    always_comb begin
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        ramaddr  = '0;
        ramstore = '0;
        ramren   = 1'b0;
        ramwen   = 1'b0;
        mem_err  = xfer_err;
        case (state_q)
            I_XFER: begin
                ramaddr = iaddr;
                ramren  = iren;
                if (xfer_done) begin
                    ihit  = 1'b1;
                    iload = ramload;
                end
            end
            D_XFER: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramren   = d_read;
                ramwen   = dwen;
                if (xfer_done) begin
                    dhit = 1'b1;
                    if (dwen && dsc) begin
                        dload = DATA_W'(1);
                    end else if (d_read) begin
                        dload = ramload;
                    end
                end
            end
            SC_FAIL: dhit = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-ported RAM between the pipeline's instruction-fetch port and data-memory port.
- Generates the ihit/dhit pulses consumed by the pipeline hazard/stall logic.
- Data accesses have priority, with a bounded-starvation guarantee for fetch.
- Owns the LL/SC link register and resolves store-conditional success/failure locally.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
MAX_DSTREAK, 4, max consecutive data grants while a fetch is pending before fetch is forced; 1..15

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
iren  in  1  fetch request; held until ihit or withdrawn
iaddr  in  ADDR_W  fetch address
ihit  out  1  fetch complete, one-cycle pulse
iload  out  DATA_W  fetch data, valid when ihit=1
dren  in  1  data read request (LW/LL)
dwen  in  1  data write request (SW/SC)
dll  in  1  qualifies dren as load-linked
dsc  in  1  qualifies dwen as store-conditional
daddr  in  ADDR_W  data address
dstore  in  DATA_W  write data
dhit  out  1  data access complete, one-cycle pulse
dload  out  DATA_W  read data; for SC: 1 = success, 0 = fail
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramren  out  1  RAM read strobe
ramwen  out  1  RAM write strobe
ramload  in  DATA_W  RAM read data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS (transfer done this cycle), 3 ERROR
mem_err  out  1  one-cycle pulse on RAM ERROR

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST).
- Reset:
  - state = IDLE, dstreak = 0, link_valid = 0, link_addr = 0.
  - All outputs 0, including ramren/ramwen.
  - Reset asserted mid-transfer drops RAM strobes on the next edge. No hit is issued.
- States:
  - IDLE: no RAM strobes; arbitrates.
  - I_XFER: ramaddr = iaddr, ramren = 1.
  - D_XFER: ramaddr = daddr; ramren = dren or ramwen = dwen; ramstore = dstore.
  - SC_FAIL: no RAM access.
- Arbitration in IDLE, registered; the transfer state begins next cycle:
  - dwen & dsc & !(link_valid & link_addr == daddr) -> SC_FAIL.
  - Else if (dren | dwen) & !(iren & dstreak == MAX_DSTREAK) -> D_XFER.
  - Else if iren -> I_XFER.
  - Else stay in IDLE.
- dren and dwen both high is illegal: treat as a write, do not assert ramren.
- Completion, in I_XFER/D_XFER when ramstate == ACCESS:
  - Assert ihit or dhit combinationally in that cycle.
  - iload/dload = ramload (reads); dload = 1 for a successful SC.
  - Next state = IDLE.
  - Minimum latency from request to hit is 2 cycles (zero-wait RAM).
- Hits, iload and dload are 0 whenever not in a completing cycle.
- SC_FAIL: dhit = 1, dload = 0 for exactly one cycle, then IDLE. No ramwen is issued.
- Withdrawal: if the owning request drops during I_XFER/D_XFER before ACCESS (branch flush), deassert strobes and go IDLE next cycle. No hit, no link update.
- ERROR: ramstate == 3 in a transfer state:
  - mem_err pulses, no hit, go IDLE.
  - The request is re-arbitrated, so the retry is automatic.
- FREE/BUSY: hold state and strobes.
- Fairness counter dstreak (4 bits):
  - +1 on each D_XFER grant made while iren = 1.
  - Cleared on any I_XFER grant or when iren = 0 in IDLE.
  - Saturates at MAX_DSTREAK.
- Link register:
  - Completed LL: link_valid = 1, link_addr = daddr.
  - Completed SC (success): link_valid = 0.
  - Completed plain write with daddr == link_addr: link_valid = 0.
  - Write to another address: link unchanged.
  - LL completing while a link is valid overwrites the link.
- Address compare is full-width ADDR_W.

Test Plan:
- Reset then iren = 1, iaddr = 0x40, ramstate = ACCESS with ramload = 0x8C010004 -> ramren seen at cycle 1; ihit = 1 and iload = 0x8C010004 at cycle 1; then IDLE; all outputs 0 during reset.
- iren and dren both held, daddr = 0x100, ramstate always ACCESS -> grant order D,D,D,D,I (MAX_DSTREAK = 4); dstreak returns to 0 after the fetch grant.
- LL 0x200 completes, then SC to 0x200 with dstore = 0x55 -> ramwen = 1, ramstore = 0x55, dhit with dload = 1; a second SC to 0x200 -> SC_FAIL, dhit with dload = 0, no ramwen.
- LL 0x200, then SW to 0x200, then SC to 0x200 -> SC fails (dload = 0); repeat with SW to 0x204 -> SC succeeds.
- In I_XFER with ramstate = BUSY for 3 cycles, drop iren -> ramren = 0 next cycle, no ihit, state IDLE; with ramstate = ERROR instead -> mem_err pulses once, ihit = 0, fetch retried and completes on a later ACCESS.
- Assert RST during D_XFER with ramstate = BUSY -> ramwen/ramren = 0 after the edge, dhit never pulses, link_valid = 0.
